// File: rtl/platform_pkg.sv
// -----------------------------------------------------------------------------
// platform_pkg -- shared platform constants and UART receiver state encoding.
//
// Contents:
//   CLKS_PER_BAUD    default clock cycles per UART bit (>= 4)
//   UART_DATA_BITS   data bits per UART frame
//   uart_rx_state_t  receiver FSM states
//
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package platform_pkg;

  localparam int unsigned CLKS_PER_BAUD  = 16;
  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage : platform_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo -- single-clock FIFO, 2**DEPTH_POT entries of WIDTH bits.
//
// Ports:
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   push_i/data_i  write request and data; accepted when not full or when a
//                  pop happens in the same cycle
//   pop_i          read request; ignored when empty
//   data_o         head entry (0 while empty)
//   full_o/empty_o occupancy flags
//   level_o        number of stored entries
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH_POT = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DEPTH_POT:0]   level_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_POT;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH_POT-1:0] wr_ptr_q;
  logic [DEPTH_POT-1:0] rd_ptr_q;
  logic [DEPTH_POT:0]   level_q;
  logic                 do_push;
  logic                 do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (DEPTH_POT+1)'(DEPTH));
  assign level_o = level_q;
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // take a push when it is also being popped.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: storage has no reset; only pointers and level define what is valid,
  // and data_o is masked while empty so stale contents never leak out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      // Pointers are exactly DEPTH_POT bits wide and wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

endmodule : sync_fifo

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo -- 8N1 UART receiver feeding a byte FIFO.
//
// Ports:
//   clk_i        sole clock (posedge)
//   rstn_i       asynchronous active-low reset
//   uart_rx_i    serial line, idle high, asynchronous to clk_i
//   valid_o      FIFO non-empty; data_o holds the oldest byte
//   data_o       head-of-FIFO byte
//   ready_i      consumer pop, effective when valid_o is high
//   level_o      bytes currently stored
//   busy_o       receiver not in IDLE
//   frame_err_o  one-cycle pulse on bad stop bit (or parity mismatch)
//   overrun_o    one-cycle pulse when a good byte is dropped on a full FIFO
//
// Optional feature macro: UART_RX_PARITY_EN -- one even-parity bit after the
// data bits; a mismatch is reported as a frame error and the byte dropped.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BAUD  = platform_pkg::CLKS_PER_BAUD,
  parameter int unsigned FIFO_DEPTH_POT = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    uart_rx_i,
  output logic                    valid_o,
  output logic [7:0]              data_o,
  input  logic                    ready_i,
  output logic [FIFO_DEPTH_POT:0] level_o,
  output logic                    busy_o,
  output logic                    frame_err_o,
  output logic                    overrun_o
);

  import platform_pkg::*;

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BAUD);
  localparam logic [CNT_W-1:0] BAUD_MAX = CNT_W'(CLKS_PER_BAUD - 1);
  // Start bit is re-checked half a bit in, which aligns data samples to mid-bit.
  localparam logic [CNT_W-1:0] HALF_MAX = CNT_W'(CLKS_PER_BAUD / 2 - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic [1:0]                sync_q;
  logic                      rx_s;
  uart_rx_state_t            state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      frame_err_q;
  logic                      overrun_q;
  logic                      baud_tick;
  logic                      push;
  logic                      fifo_full;
  logic                      fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                      par_err_q;
`endif

  // Two-flop synchronizer; resets to the idle level so no false start bit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], uart_rx_i};
  end
  assign rx_s = sync_q[1];

  assign baud_tick = (cnt_q == BAUD_MAX);

  // Push is decoded combinationally on the stop-sample cycle so the byte is
  // visible at the FIFO output on the very next cycle.
`ifdef UART_RX_PARITY_EN
  assign push = (state_q == STOP) && baud_tick && rx_s && !par_err_q;
`else
  assign push = (state_q == STOP) && baud_tick && rx_s;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rx_s) state_q <= START;
        end
        START: begin
          if (cnt_q == HALF_MAX) begin
            cnt_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_tick) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx_q == LAST_BIT) state_q <= PARITY;
`else
            if (bit_idx_q == LAST_BIT) state_q <= STOP;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            cnt_q     <= '0;
            par_err_q <= rx_s ^ (^shift_q);
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            cnt_q <= '0;
            if (!rx_s) begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end else begin
`ifdef UART_RX_PARITY_EN
              frame_err_q <= par_err_q;
`endif
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // A held-low line (break) reports one error, then waits for idle.
        WAIT_HIGH: if (rx_s) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) overrun_q <= 1'b0;
    else         overrun_q <= push && fifo_full && !ready_i;
  end

  sync_fifo #(
    .WIDTH    (UART_DATA_BITS),
    .DEPTH_POT(FIFO_DEPTH_POT)
  ) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push_i (push),
    .data_i (shift_q),
    .pop_i  (ready_i),
    .data_o (data_o),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(level_o)
  );

  assign valid_o     = !fifo_empty;
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo -- self-checking bench for uart_rx_fifo with
// CLKS_PER_BAUD=16 and FIFO_DEPTH_POT=2. Bytes expected to reach the FIFO are
// queued when sent and compared in order when popped.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int CPB = 16;
  localparam int POT = 2;
  // Posedges from driving the start bit to the stop-sample edge:
  // 2 sync + 1 idle detect + CPB/2 start + 9*CPB data/stop.
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic         clk = 1'b0;
  logic         rstn;
  logic         uart_rx;
  logic         valid;
  logic [7:0]   data;
  logic         ready;
  logic [POT:0] level;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           fe_cnt = 0;
  int           ov_cnt = 0;
  logic [7:0]   exp_q[$];

  uart_rx_fifo #(
    .CLKS_PER_BAUD (CPB),
    .FIFO_DEPTH_POT(POT)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .uart_rx_i  (uart_rx),
    .valid_o    (valid),
    .data_o     (data),
    .ready_i    (ready),
    .level_o    (level),
    .busy_o     (busy),
    .frame_err_o(frame_err),
    .overrun_o  (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rstn) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drives one frame starting now (caller is at a negedge).
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int hold_low);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB + hold_low) @(negedge clk);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pop_one(input string tag);
    int waited = 0;
    while (!valid && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'(data), 32'hFFFF_FFFF);
    end else begin
      check(tag, 32'(data), 32'(exp_q.pop_front()));
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_data"},  32'(data), 0);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_ferr"},  32'(frame_err), 0);
    check({tag, "_ovr"},   32'(overrun), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fe0;
    int ov0;
    uart_rx = 1'b1;
    ready   = 1'b0;
    rstn    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5: exact push latency, then pop.
    exp_q.push_back(8'hA5);
    fork
      send_byte(8'hA5, 1'b1, 0);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1;
        check("a5_valid_before", 32'(valid), 0);
        check("a5_busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        check("a5_valid_after", 32'(valid), 1);
        check("a5_level", 32'(level), 1);
      end
    join
    pop_one("a5_data");
    check("a5_valid_popped", 32'(valid), 0);
    check("a5_level_popped", 32'(level), 0);

    // Short low glitch on an idle line.
    fe0 = fe_cnt;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy", 32'(busy), 1);
    uart_rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_idle", 32'(busy), 0);
    check("glitch_level", 32'(level), 0);
    check("glitch_ferr", 32'(fe_cnt - fe0), 0);

    // 0x3C with low stop bit held low 40 more cycles.
    fe0 = fe_cnt;
    fork
      send_byte(8'h3C, 1'b0, 40);
      begin
        repeat (10 * CPB + 30) @(negedge clk);
        check("brk_wait_busy", 32'(busy), 1);
        check("brk_ferr_once", 32'(fe_cnt - fe0), 1);
      end
    join
    check("brk_ferr_total", 32'(fe_cnt - fe0), 1);
    check("brk_level", 32'(level), 0);
    check("brk_idle", 32'(busy), 0);

    // Overrun: five bytes into a four-deep FIFO without popping.
    ov0 = ov_cnt;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1, 0);
    end
    check("ovr_level", 32'(level), 4);
    check("ovr_pulses", 32'(ov_cnt - ov0), 1);
    for (int i = 0; i < 4; i++) pop_one("ovr_data");
    check("ovr_drained", 32'(valid), 0);

    // Full FIFO, 5th byte's stop sample coincides with a pop.
    ov0 = ov_cnt;
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1, 0);
    end
    check("fullpop_level_pre", 32'(level), 4);
    exp_q.push_back(8'h05);
    fork
      send_byte(8'h05, 1'b1, 0);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        @(negedge clk);
        check("fullpop_head", 32'(data), 32'(exp_q.pop_front()));
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("fullpop_level_now", 32'(level), 4);
      end
    join
    check("fullpop_no_ovr", 32'(ov_cnt - ov0), 0);
    check("fullpop_level", 32'(level), 4);
    for (int i = 0; i < 4; i++) pop_one("fullpop_data");

    // Reset during data bit 3 of 0x7E, with one byte already stored.
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1, 0);
    check("rst_pre_level", 32'(level), 1);
    fork
      send_byte(8'h7E, 1'b1, 0);
      begin
        repeat (3 + CPB / 2 + 3 * CPB + 8) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
      end
    join
    exp_q.delete();
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    exp_q.push_back(8'h42);
    send_byte(8'h42, 1'b1, 0);
    check("post_rst_level", 32'(level), 1);
    pop_one("post_rst_data");
    check("final_empty", 32'(valid), 0);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_uart_rx_fifo
